dual_port_ram_param: RTL and testbench

Parametrised true dual-port synchronous RAM, successor to the single-port-interface `dual_port_ram`. Two fully independent ports (A, B) share one storage array on one clock. Each port can read or write every cycle. The block adds configurable read-during-write semantics, an optional output register stage, per-port read-valid strobes and same-address collision detection. It is the storage element for shared buffers between two producer/consumer agents in the datapath.

---
 rtl/dual_port_ram_param.sv | 133 +++++++++++++
 tb/tb_dual_port_ram_param.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_param.sv
// ============================================================================
// Module      : dual_port_ram_param
// Description : True dual-port synchronous RAM with selectable read-during-
//               write behaviour, optional output register, per-port read-valid
//               strobes and same-address write collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram_param #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_a,
    input  logic              wr_a,
    input  logic              rd_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] dataIn_a,
    output logic [DATA_W-1:0] dataOut_a,
    output logic              valid_a,
    input  logic              cs_b,
    input  logic              wr_b,
    input  logic              rd_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] dataIn_b,
    output logic [DATA_W-1:0] dataOut_b,
    output logic              valid_b,
    output logic              collision
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_we_a, w_we_b, w_we_b_eff;
    logic              w_rd_a, w_rd_b;
    logic              w_same, w_collide;
    logic [DATA_W-1:0] w_rdata_a, w_rdata_b;
    logic [DATA_W-1:0] r_dout_a, r_dout_b;
    logic              r_valid_a, r_valid_b, r_collision;

    assign w_we_a     = cs_a & wr_a;
    assign w_we_b     = cs_b & wr_b;
    assign w_rd_a     = cs_a & rd_a;
    assign w_rd_b     = cs_b & rd_b;
    assign w_same     = (addr_a == addr_b);
    assign w_collide  = w_we_a & w_we_b & w_same;
    // Port A owns the word when both ports write the same address.
    assign w_we_b_eff = w_we_b & ~w_collide;

    always_ff @(posedge clk) begin
        if (w_we_b_eff) r_mem[addr_b] <= dataIn_b;
        if (w_we_a)     r_mem[addr_a] <= dataIn_a;
    end

    generate
        if (RDW_MODE != 0) begin : g_rdw_new
            // Write-through: a same-cycle write to the read address forwards its data.
            always_comb begin
                w_rdata_a = r_mem[addr_a];
                if (w_we_a)                   w_rdata_a = dataIn_a;
                else if (w_we_b_eff && w_same) w_rdata_a = dataIn_b;
                w_rdata_b = r_mem[addr_b];
                if (w_we_a && w_same)         w_rdata_b = dataIn_a;
                else if (w_we_b)              w_rdata_b = dataIn_b;
            end
        end else begin : g_rdw_old
            assign w_rdata_a = r_mem[addr_a];
            assign w_rdata_b = r_mem[addr_b];
        end
    endgenerate

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_pvld_a, r_pvld_b;
            logic [DATA_W-1:0] r_pdat_a, r_pdat_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pvld_a  <= 1'b0;
                    r_pvld_b  <= 1'b0;
                    r_pdat_a  <= '0;
                    r_pdat_b  <= '0;
                    r_valid_a <= 1'b0;
                    r_valid_b <= 1'b0;
                    r_dout_a  <= '0;
                    r_dout_b  <= '0;
                end else begin
                    r_pvld_a  <= w_rd_a;
                    r_pvld_b  <= w_rd_b;
                    if (w_rd_a) r_pdat_a <= w_rdata_a;
                    if (w_rd_b) r_pdat_b <= w_rdata_b;
                    r_valid_a <= r_pvld_a;
                    r_valid_b <= r_pvld_b;
                    if (r_pvld_a) r_dout_a <= r_pdat_a;
                    if (r_pvld_b) r_dout_b <= r_pdat_b;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid_a <= 1'b0;
                    r_valid_b <= 1'b0;
                    r_dout_a  <= '0;
                    r_dout_b  <= '0;
                end else begin
                    r_valid_a <= w_rd_a;
                    r_valid_b <= w_rd_b;
                    if (w_rd_a) r_dout_a <= w_rdata_a;
                    if (w_rd_b) r_dout_b <= w_rdata_b;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_collision <= 1'b0;
        else        r_collision <= w_collide;
    end

    assign dataOut_a = r_dout_a;
    assign dataOut_b = r_dout_b;
    assign valid_a   = r_valid_a;
    assign valid_b   = r_valid_b;
    assign collision = r_collision;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_param.sv
// ============================================================================
// Module      : tb_dual_port_ram_param
// Description : Scoreboard bench for two RAM configurations (4-bit/256 words,
//               read-first, latency 1) and (16-bit/16 words, write-through,
//               latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_port_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cs_a [2], wr_a [2], rd_a [2], cs_b [2], wr_b [2], rd_b [2];
    logic        vld_a [2], vld_b [2], coll [2];
    logic [7:0]  addr_a0, addr_b0;
    logic [3:0]  addr_a1, addr_b1;
    logic [3:0]  din_a0, din_b0, dout_a0, dout_b0;
    logic [15:0] din_a1, din_b1, dout_a1, dout_b1;

    dual_port_ram_param #(.DATA_W(4), .ADDR_W(8), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cs_a(cs_a[0]), .wr_a(wr_a[0]), .rd_a(rd_a[0]), .addr_a(addr_a0),
        .dataIn_a(din_a0), .dataOut_a(dout_a0), .valid_a(vld_a[0]),
        .cs_b(cs_b[0]), .wr_b(wr_b[0]), .rd_b(rd_b[0]), .addr_b(addr_b0),
        .dataIn_b(din_b0), .dataOut_b(dout_b0), .valid_b(vld_b[0]),
        .collision(coll[0])
    );

    dual_port_ram_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cs_a(cs_a[1]), .wr_a(wr_a[1]), .rd_a(rd_a[1]), .addr_a(addr_a1),
        .dataIn_a(din_a1), .dataOut_a(dout_a1), .valid_a(vld_a[1]),
        .cs_b(cs_b[1]), .wr_b(wr_b[1]), .rd_b(rd_b[1]), .addr_b(addr_b1),
        .dataIn_b(din_b1), .dataOut_b(dout_b1), .valid_b(vld_b[1]),
        .collision(coll[1])
    );

    int nchecks = 0;
    int nerrors = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb [4][$];
    logic [15:0] mdl [2][256];
    int          exp_coll_cyc [2];

    logic        mv [4];
    logic [15:0] md [4];
    assign mv[0] = vld_a[0];
    assign mv[1] = vld_b[0];
    assign mv[2] = vld_a[1];
    assign mv[3] = vld_b[1];
    assign md[0] = {12'h000, dout_a0};
    assign md[1] = {12'h000, dout_b0};
    assign md[2] = dout_a1;
    assign md[3] = dout_b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid pulse must match the oldest expected read
    // on that port, on exactly the cycle the configured latency predicts.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (mv[i]) begin
                    nchecks++;
                    if (sb[i].size() == 0) begin
                        nerrors++;
                        $display("FAIL sb_unexpected_valid port=%0d cyc=%0d got=%h required=no_valid", i, cyc, md[i]);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        if (md[i] !== e.data || cyc != e.due) begin
                            nerrors++;
                            $display("FAIL sb_read port=%0d got=%h@%0d required=%h@%0d", i, md[i], cyc, e.data, e.due);
                        end
                    end
                end else if (sb[i].size() > 0 && sb[i][0].due < cyc) begin
                    exp_t e;
                    nchecks++;
                    nerrors++;
                    e = sb[i].pop_front();
                    $display("FAIL sb_missing_valid port=%0d got=none@%0d required=%h@%0d", i, cyc, e.data, e.due);
                end
            end
            for (int d = 0; d < 2; d++) begin
                nchecks++;
                if (coll[d] !== (cyc == exp_coll_cyc[d])) begin
                    nerrors++;
                    $display("FAIL collision dut=%0d cyc=%0d got=%b required=%b", d, cyc, coll[d], (cyc == exp_coll_cyc[d]));
                end
            end
        end
    end

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            cs_a[d] = 1'b0; wr_a[d] = 1'b0; rd_a[d] = 1'b0;
            cs_b[d] = 1'b0; wr_b[d] = 1'b0; rd_b[d] = 1'b0;
        end
        addr_a0 = '0; addr_b0 = '0; addr_a1 = '0; addr_b1 = '0;
        din_a0  = '0; din_b0  = '0; din_a1  = '0; din_b1  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one cycle on DUT d and pushes expected read results from the model.
    task automatic op(input int d,
                      input logic csa, input logic wra, input logic rda,
                      input logic [7:0] aa, input logic [15:0] da,
                      input logic csb, input logic wrb, input logic rdb,
                      input logic [7:0] ab, input logic [15:0] db);
        logic [15:0] m, ra, rb;
        logic [7:0]  am;
        logic        wea, web, col;
        exp_t        e;
        m  = (d == 0) ? 16'h000F : 16'hFFFF;
        am = (d == 0) ? 8'hFF : 8'h0F;
        aa = aa & am; ab = ab & am; da = da & m; db = db & m;
        cs_a[d] = csa; wr_a[d] = wra; rd_a[d] = rda;
        cs_b[d] = csb; wr_b[d] = wrb; rd_b[d] = rdb;
        if (d == 0) begin
            addr_a0 = aa; addr_b0 = ab; din_a0 = da[3:0]; din_b0 = db[3:0];
        end else begin
            addr_a1 = aa[3:0]; addr_b1 = ab[3:0]; din_a1 = da; din_b1 = db;
        end
        wea = csa & wra;
        web = csb & wrb;
        col = wea & web & (aa == ab);
        if (d == 1) begin
            ra = wea ? da : ((web && ab == aa) ? db : mdl[d][aa]);
            rb = (wea && aa == ab) ? da : (web ? db : mdl[d][ab]);
        end else begin
            ra = mdl[d][aa];
            rb = mdl[d][ab];
        end
        if (csa && rda) begin
            e.data = ra; e.due = cyc + ((d == 0) ? 1 : 2);
            sb[d*2].push_back(e);
        end
        if (csb && rdb) begin
            e.data = rb; e.due = cyc + ((d == 0) ? 1 : 2);
            sb[d*2+1].push_back(e);
        end
        if (col) exp_coll_cyc[d] = cyc + 1;
        if (web && !col) mdl[d][ab] = db;
        if (wea)         mdl[d][aa] = da;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            for (int d = 0; d < 2; d++) begin
                cs_a[d] = 1'($urandom); wr_a[d] = 1'($urandom); rd_a[d] = 1'($urandom);
                cs_b[d] = 1'($urandom); wr_b[d] = 1'($urandom); rd_b[d] = 1'($urandom);
            end
            addr_a0 = 8'($urandom); addr_b0 = 8'($urandom);
            addr_a1 = 4'($urandom); addr_b1 = 4'($urandom);
            din_a0  = 4'($urandom); din_b0  = 4'($urandom);
            din_a1  = 16'($urandom); din_b1 = 16'($urandom);
            @(posedge clk);
            #1;
        end
        nchecks++;
        if ({dout_a0, dout_b0} !== 8'h00) begin
            nerrors++; $display("FAIL reset_data0 got=%h required=00", {dout_a0, dout_b0});
        end
        nchecks++;
        if ({dout_a1, dout_b1} !== 32'h0) begin
            nerrors++; $display("FAIL reset_data1 got=%h required=00000000", {dout_a1, dout_b1});
        end
        nchecks++;
        if ({vld_a[0], vld_b[0], coll[0]} !== 3'b000) begin
            nerrors++; $display("FAIL reset_flags0 got=%b required=000", {vld_a[0], vld_b[0], coll[0]});
        end
        nchecks++;
        if ({vld_a[1], vld_b[1], coll[1]} !== 3'b000) begin
            nerrors++; $display("FAIL reset_flags1 got=%b required=000", {vld_a[1], vld_b[1], coll[1]});
        end
        clear_inputs();
        rst_n = 1'b1;
        idle(3);
        nchecks++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1} !== 40'h0) begin
            nerrors++; $display("FAIL idle_after_reset got=%h required=0", {dout_a0, dout_b0, dout_a1, dout_b1});
        end
    endtask

    task automatic test_basic();
        op(0, 1, 1, 0, 8'd1, 16'hF, 0, 0, 0, 8'd0, 16'h0);
        op(0, 1, 1, 0, 8'd2, 16'hE, 0, 0, 0, 8'd0, 16'h0);
        op(0, 1, 1, 0, 8'd3, 16'hD, 0, 0, 0, 8'd0, 16'h0);
        op(0, 0, 0, 0, 8'd0, 16'h0, 1, 0, 1, 8'd1, 16'h0);
        op(0, 0, 0, 0, 8'd0, 16'h0, 1, 0, 1, 8'd2, 16'h0);
        op(0, 0, 0, 0, 8'd0, 16'h0, 1, 0, 1, 8'd3, 16'h0);
        idle(3);
        nchecks++;
        if (dout_b0 !== 4'hD || vld_b[0] !== 1'b0) begin
            nerrors++; $display("FAIL basic_hold got=%h/%b required=d/0", dout_b0, vld_b[0]);
        end
    endtask

    task automatic test_rdw(input int d);
        logic [15:0] want;
        logic [15:0] got;
        want = (d == 1) ? 16'hA : 16'h3;
        op(d, 1, 1, 0, 8'd5, 16'h3, 0, 0, 0, 8'd0, 16'h0);
        op(d, 1, 1, 0, 8'd5, 16'hA, 1, 0, 1, 8'd5, 16'h0);
        op(d, 1, 1, 0, 8'd5, 16'h3, 0, 0, 0, 8'd0, 16'h0);
        op(d, 1, 1, 1, 8'd5, 16'hA, 0, 0, 0, 8'd0, 16'h0);
        idle(4);
        got = (d == 0) ? {12'h000, dout_a0} : dout_a1;
        nchecks++;
        if (got !== want) begin
            nerrors++; $display("FAIL rdw_same_port dut=%0d got=%h required=%h", d, got, want);
        end
        got = (d == 0) ? {12'h000, dout_b0} : dout_b1;
        nchecks++;
        if (got !== want) begin
            nerrors++; $display("FAIL rdw_cross_port dut=%0d got=%h required=%h", d, got, want);
        end
    endtask

    task automatic test_collision();
        op(0, 1, 1, 0, 8'd7, 16'h1, 1, 1, 0, 8'd7, 16'h2);
        nchecks++;
        if (coll[0] !== 1'b1) begin
            nerrors++; $display("FAIL collision_pulse got=%b required=1", coll[0]);
        end
        idle(1);
        nchecks++;
        if (coll[0] !== 1'b0) begin
            nerrors++; $display("FAIL collision_single got=%b required=0", coll[0]);
        end
        op(0, 1, 0, 1, 8'd7, 16'h0, 0, 0, 0, 8'd0, 16'h0);
        idle(2);
        nchecks++;
        if (dout_a0 !== 4'h1) begin
            nerrors++; $display("FAIL collision_winner got=%h required=1", dout_a0);
        end
        op(0, 1, 1, 0, 8'd7, 16'h5, 1, 1, 0, 8'd8, 16'h6);
        op(0, 1, 0, 1, 8'd8, 16'h0, 1, 0, 1, 8'd7, 16'h0);
        op(0, 1, 1, 0, 8'd9, 16'h3, 0, 0, 0, 8'd0, 16'h0);
        op(0, 1, 1, 0, 8'd9, 16'h9, 1, 1, 1, 8'd9, 16'hC);
        op(0, 0, 0, 0, 8'd0, 16'h0, 1, 0, 1, 8'd9, 16'h0);
        op(1, 1, 1, 1, 8'd9, 16'h1234, 1, 1, 1, 8'd9, 16'h5678);
        op(1, 1, 0, 1, 8'd9, 16'h0, 0, 0, 0, 8'd0, 16'h0);
        idle(4);
        nchecks++;
        if (dout_a1 !== 16'h1234) begin
            nerrors++; $display("FAIL collision_wide got=%h required=1234", dout_a1);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++)
            op(1, 1, 1, 0, 8'(i), 16'(i) ^ 16'hA5A5, 0, 0, 0, 8'd0, 16'h0);
        for (int i = 0; i < 16; i++)
            op(1, 1, 0, 1, 8'(15 - i), 16'h0, 1, 0, 1, 8'(i), 16'h0);
        idle(4);
        nchecks++;
        if (dout_b1 !== 16'hA5AA || dout_a1 !== 16'hA5A5) begin
            nerrors++; $display("FAIL sweep_last got=%h/%h required=a5aa/a5a5", dout_b1, dout_a1);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 6; i++)
            op(1, 1, 0, 1, 8'(i + 4), 16'h0, 1, 0, 1, 8'(i), 16'h0);
        for (int i = 0; i < 4; i++) sb[i].delete();
        exp_coll_cyc[0] = -1;
        exp_coll_cyc[1] = -1;
        rst_n = 1'b0;
        #1;
        nchecks++;
        if ({dout_a1, dout_b1, vld_a[1], vld_b[1]} !== 34'h0) begin
            nerrors++; $display("FAIL midop_reset got=%h/%h/%b%b required=0", dout_a1, dout_b1, vld_a[1], vld_b[1]);
        end
        idle(2);
        rst_n = 1'b1;
        idle(4);
        nchecks++;
        if ({dout_a1, dout_b1, dout_a0, dout_b0} !== 40'h0) begin
            nerrors++; $display("FAIL midop_release got=%h required=0", {dout_a1, dout_b1, dout_a0, dout_b0});
        end
        op(1, 1, 0, 1, 8'd10, 16'h0, 1, 0, 1, 8'd3, 16'h0);
        op(1, 1, 0, 1, 8'd9, 16'h0, 1, 0, 1, 8'd15, 16'h0);
        op(0, 1, 0, 1, 8'd1, 16'h0, 1, 0, 1, 8'd7, 16'h0);
        idle(4);
        nchecks++;
        if (dout_a0 !== 4'hF || dout_b0 !== 4'h5) begin
            nerrors++; $display("FAIL midop_retained got=%h/%h required=f/5", dout_a0, dout_b0);
        end
    endtask

    initial begin
        exp_coll_cyc[0] = -1;
        exp_coll_cyc[1] = -1;
        clear_inputs();
        test_reset();
        test_basic();
        test_rdw(0);
        test_rdw(1);
        test_collision();
        test_sweep();
        test_reset_midop();
        idle(2);
        nchecks++;
        if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0) begin
            nerrors++;
            $display("FAIL sb_drain got=%0d required=0", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

`default_nettype wire
